// File: rtl/axi_pkg.sv
// AXI response encoding shared by the AXI-Lite register bank and its decoders.
package axi_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_regs_decode.sv
// Combinational byte-address to register-index decode for the AXI-Lite register bank.
module axi_lite_regs_decode #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter int                    IDX_W      = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_hit
);

    localparam int SHIFT = $clog2(DATA_WIDTH / 8);

    logic [ADDR_WIDTH:0]   w_diff;
    logic [ADDR_WIDTH-1:0] w_word;

    // The extra top bit is the borrow: set when the address lies below BASE_ADDR.
    assign w_diff = {1'b0, i_addr} - {1'b0, BASE_ADDR};
    assign w_word = w_diff[ADDR_WIDTH-1:0] >> SHIFT;
    assign o_hit  = !w_diff[ADDR_WIDTH] && (w_word < ADDR_WIDTH'(NUM_REGS));
    assign o_idx  = w_word[IDX_W-1:0];

endmodule

// File: rtl/axi_lite_regs.sv
// AXI4-Lite responder exposing NUM_REGS registers with byte strobes, read-only mask and hardware load.
// Define AXI_LITE_REGS_WR_PULSE_EN to add the wr_pulse_o per-register write strobe output.
module axi_lite_regs
    import axi_pkg::*;
#(
    parameter int                               ADDR_WIDTH = 32,
    parameter int                               DATA_WIDTH = 32,
    parameter int                               NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0]            BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]              READ_ONLY  = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [ADDR_WIDTH-1:0]            aw_addr_i,
    input  logic                             aw_valid_i,
    output logic                             aw_ready_o,
    input  logic [DATA_WIDTH-1:0]            w_data_i,
    input  logic [DATA_WIDTH/8-1:0]          w_strb_i,
    input  logic                             w_valid_i,
    output logic                             w_ready_o,
    output resp_t                            b_resp_o,
    output logic                             b_valid_o,
    input  logic                             b_ready_i,
    input  logic [ADDR_WIDTH-1:0]            ar_addr_i,
    input  logic                             ar_valid_i,
    output logic                             ar_ready_o,
    output logic [DATA_WIDTH-1:0]            r_data_o,
    output resp_t                            r_resp_o,
    output logic                             r_valid_o,
    input  logic                             r_ready_i,
`ifdef AXI_LITE_REGS_WR_PULSE_EN
    output logic [NUM_REGS-1:0]              wr_pulse_o,
`endif
    output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_q_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   reg_d_i,
    input  logic [NUM_REGS-1:0]              reg_load_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [0:0] WR_IDLE = 1'b0;
    localparam logic [0:0] WR_RESP = 1'b1;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_RESP = 1'b1;

    logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];

    logic [0:0]             r_wr_state;
    logic                   r_aw_full;
    logic [ADDR_WIDTH-1:0]  r_aw_addr;
    logic                   r_w_full;
    logic [DATA_WIDTH-1:0]  r_w_data;
    logic [STRB_W-1:0]      r_w_strb;
    resp_t                  r_b_resp;

    logic [0:0]             r_rd_state;
    logic [DATA_WIDTH-1:0]  r_r_data;
    resp_t                  r_r_resp;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_commit;
    logic [ADDR_WIDTH-1:0]  w_wr_addr;
    logic [DATA_WIDTH-1:0]  w_wr_data;
    logic [STRB_W-1:0]      w_wr_strb;
    logic [IDX_W-1:0]       w_wr_idx;
    logic                   w_wr_hit;
    resp_t                  w_wr_resp;
    logic [NUM_REGS-1:0]    w_wr_en;

    logic [IDX_W-1:0]       w_rd_idx;
    logic                   w_rd_hit;

    // ------------------------------------------------------------------ write path
    assign aw_ready_o = (r_wr_state == WR_IDLE) && !r_aw_full;
    assign w_ready_o  = (r_wr_state == WR_IDLE) && !r_w_full;
    assign w_aw_hs    = aw_valid_i && aw_ready_o;
    assign w_w_hs     = w_valid_i && w_ready_o;

    // Address and data may each come from the buffer or from a handshake this cycle.
    assign w_commit   = (r_wr_state == WR_IDLE) && (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
    assign w_wr_addr  = r_aw_full ? r_aw_addr : aw_addr_i;
    assign w_wr_data  = r_w_full  ? r_w_data  : w_data_i;
    assign w_wr_strb  = r_w_full  ? r_w_strb  : w_strb_i;

    axi_lite_regs_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W),
        .BASE_ADDR  (BASE_ADDR)
    ) u_wr_decode (
        .i_addr (w_wr_addr),
        .o_idx  (w_wr_idx),
        .o_hit  (w_wr_hit)
    );

    always_comb begin
        w_wr_resp = RESP_OKAY;
        if (!w_wr_hit) begin
            w_wr_resp = RESP_DECERR;
        end else if (READ_ONLY[w_wr_idx]) begin
            w_wr_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_state <= WR_IDLE;
            r_aw_full  <= 1'b0;
            r_aw_addr  <= '0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_b_resp   <= RESP_OKAY;
        end else if (r_wr_state == WR_IDLE) begin
            if (w_commit) begin
                r_wr_state <= WR_RESP;
                r_b_resp   <= w_wr_resp;
                r_aw_full  <= 1'b0;
                r_w_full   <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_addr <= aw_addr_i;
                end
                if (w_w_hs) begin
                    r_w_full <= 1'b1;
                    r_w_data <= w_data_i;
                    r_w_strb <= w_strb_i;
                end
            end
        end else if (b_ready_i) begin
            r_wr_state <= WR_IDLE;
        end
    end

    assign b_valid_o = (r_wr_state == WR_RESP);
    assign b_resp_o  = r_b_resp;

    // ------------------------------------------------------------------ register bank
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign w_wr_en[gi] = w_commit && w_wr_hit && (w_wr_idx == IDX_W'(gi)) && !READ_ONLY[gi];

            // Hardware load wins over a bus write landing on the same edge.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_regs[gi] <= RESET_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
                end else if (reg_load_i[gi]) begin
                    r_regs[gi] <= reg_d_i[gi*DATA_WIDTH +: DATA_WIDTH];
                end else if (w_wr_en[gi]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_wr_strb[b]) begin
                            r_regs[gi][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                        end
                    end
                end
            end

            assign reg_q_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

`ifdef AXI_LITE_REGS_WR_PULSE_EN
    logic [NUM_REGS-1:0] r_wr_pulse;

    // w_wr_en is only set for OKAY hits, so it doubles as the pulse source.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= (|w_wr_strb) ? w_wr_en : '0;
        end
    end

    assign wr_pulse_o = r_wr_pulse;
`endif

    // ------------------------------------------------------------------ read path
    axi_lite_regs_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W),
        .BASE_ADDR  (BASE_ADDR)
    ) u_rd_decode (
        .i_addr (ar_addr_i),
        .o_idx  (w_rd_idx),
        .o_hit  (w_rd_hit)
    );

    assign ar_ready_o = (r_rd_state == RD_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_state <= RD_IDLE;
            r_r_data   <= '0;
            r_r_resp   <= RESP_OKAY;
        end else if (r_rd_state == RD_IDLE) begin
            if (ar_valid_i) begin
                r_rd_state <= RD_RESP;
                r_r_data   <= w_rd_hit ? r_regs[w_rd_idx] : '0;
                r_r_resp   <= w_rd_hit ? RESP_OKAY : RESP_DECERR;
            end
        end else if (r_ready_i) begin
            r_rd_state <= RD_IDLE;
        end
    end

    assign r_valid_o = (r_rd_state == RD_RESP);
    assign r_data_o  = r_r_data;
    assign r_resp_o  = r_r_resp;

endmodule
